mem_reader: RTL
===============

MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the snapshot queue depth in entries; legal values are powers of two from 2 to 16.
REQ-002 in_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 in_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 in_mem  input  6  SHALL carry the stored pattern from the memory register output.
REQ-005 mem_wrt_rd  input  1  SHALL be the one-cycle write-done strobe from the memory register; while high, in_mem holds the newly written value.
REQ-006 in_ready  input  1  SHALL be the downstream consumer ready signal.
REQ-007 in_clr_ovf  input  1  SHALL be the overflow-flag clear pulse.
REQ-008 out_data  output  6  SHALL carry the head-of-queue snapshot.
REQ-009 out_valid  output  1  SHALL indicate that out_data holds a valid snapshot.
REQ-010 out_count  output  $clog2(DEPTH)+1  SHALL give the number of queued entries.
REQ-011 out_overflow  output  1  SHALL be the sticky flag for a dropped snapshot.

Function
REQ-012 Capture: a cycle with mem_wrt_rd=1 SHALL be a push request carrying in_mem as sampled in that same cycle.
REQ-013 A push SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-014 A rejected push SHALL drop the data and set out_overflow on the next edge; queue contents SHALL be unchanged.
REQ-015 Pop: a cycle with out_valid=1 and in_ready=1 SHALL remove the head entry on that edge.
REQ-016 Latency: an accepted push into an empty queue SHALL make out_valid=1 with that data on the following cycle; there SHALL be no same-cycle bypass.
REQ-017 Push and pop in the same cycle SHALL leave out_count unchanged and preserve FIFO order.
REQ-018 out_valid SHALL equal (out_count!=0).
REQ-019 out_data SHALL be 6'h3F whenever out_valid=0.
REQ-020 out_data SHALL be held stable while out_valid=1 and in_ready=0.
REQ-021 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by out_count, not by pointer equality alone.
REQ-022 Pop attempts while empty SHALL be ignored, with no underflow and no flag.
REQ-023 in_clr_ovf=1 SHALL clear out_overflow on the next edge, unless a push is rejected in that same cycle, in which case set SHALL win.
REQ-024 out_overflow SHALL affect no other behaviour; the queue keeps operating.

Reset
REQ-025 While in_rst=1 at an edge: out_count=0, out_valid=0, out_data=6'h3F, out_overflow=0, pointers=0; all push and pop requests SHALL be ignored.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries within one cycle.
REQ-027 A strobe in the first cycle after reset deasserts SHALL be accepted normally.

Configuration
REQ-028 Macro MEM_READER_DEDUP_EN defined: the block SHALL keep a last-accepted register (reset value 6'h3F).
REQ-029 With MEM_READER_DEDUP_EN defined: a push whose data equals the last-accepted register SHALL be silently discarded, SHALL not count as overflow, and SHALL leave the register unchanged.
REQ-030 With MEM_READER_DEDUP_EN defined: each accepted push SHALL update the last-accepted register; the register SHALL NOT be updated by pops.
REQ-031 Macro MEM_READER_DEDUP_EN undefined: every strobe SHALL be a push request as in REQ-012, and no last-accepted register SHALL exist.

Verification
REQ-032 After reset, strobe with in_mem=6'h15, in_ready=0 -> next cycle out_valid=1, out_data=6'h15, out_count=1; held stable for 5 cycles.
REQ-033 DEPTH=4, in_ready=0, strobes with 01,02,03,04,05 -> out_count=4, out_overflow=1; then in_ready=1 -> pops 01,02,03,04 in order, 05 lost, out_data=6'h3F once empty.
REQ-034 Full queue; strobe 6'h2A in the same cycle as a pop -> out_count stays 4, out_overflow unchanged, 6'h2A exits last.
REQ-035 Overflow rejection and in_clr_ovf=1 in the same cycle -> out_overflow=1; in_clr_ovf alone on the next cycle -> out_overflow=0.
REQ-036 Three entries queued, in_rst=1 for one cycle -> out_count=0, out_valid=0, out_data=6'h3F; a strobe with 6'h07 on the next cycle is accepted.
REQ-037 MEM_READER_DEDUP_EN defined, strobes 6'h3F,6'h10,6'h10,6'h11 -> only 10 and 11 queued, out_overflow=0; without the macro -> all four queued.

Source files
------------

// File: rtl/mem_reader.sv
// mem_reader: snapshot queue for memory-register write-done strobes.
// Optional duplicate suppression: define MEM_READER_DEDUP_EN.
module mem_reader #(
   parameter int DEPTH = 4
) (
   input  logic                     in_clk,
   input  logic                     in_rst,
   input  logic [5:0]               in_mem,
   input  logic                     mem_wrt_rd,
   input  logic                     in_ready,
   input  logic                     in_clr_ovf,
   output logic [5:0]               out_data,
   output logic                     out_valid,
   output logic [$clog2(DEPTH):0]   out_count,
   output logic                     out_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [5:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          push_req, pop, accept, reject;

`ifdef MEM_READER_DEDUP_EN
   logic [5:0]    last_q, last_d;
`endif

   // Handshake decode, pointer/count/flag next-state.
   always_comb begin
      pop      = (cnt_q != '0) && in_ready;
`ifdef MEM_READER_DEDUP_EN
      push_req = mem_wrt_rd && (in_mem != last_q);
      last_d   = last_q;
`else
      push_req = mem_wrt_rd;
`endif
      accept   = push_req && ((cnt_q != FULL) || pop);
      reject   = push_req && !accept;
      wr_d     = wr_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      if (accept) wr_d = wr_q + 1'b1;
      if (pop)    rd_d = rd_q + 1'b1;
      if (accept && !pop) cnt_d = cnt_q + 1'b1;
      if (pop && !accept) cnt_d = cnt_q - 1'b1;
      ovf_d    = reject | (ovf_q & ~in_clr_ovf);
`ifdef MEM_READER_DEDUP_EN
      if (accept) last_d = in_mem;
`endif
   end

   // Control state with synchronous reset.
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
`ifdef MEM_READER_DEDUP_EN
         last_q <= 6'h3F;
`endif
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
`ifdef MEM_READER_DEDUP_EN
         last_q <= last_d;
`endif
      end
   end

   // Snapshot storage; contents only matter where count says so.
   always_ff @(posedge in_clk) begin
      if (!in_rst && accept) mem_q[wr_q] <= in_mem;
   end

   assign out_count    = cnt_q;
   assign out_valid    = (cnt_q != '0);
   assign out_data     = out_valid ? mem_q[rd_q] : 6'h3F;
   assign out_overflow = ovf_q;

endmodule
